// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller: a CPU write to DMA_REG_ADDR halts the CPU and copies one 256-byte page to the OAM data port.
// Optional: define OAM_DMA_STALL_COUNT_EN to add the saturating stall_cycles counter output.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    output logic        bus_sel,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    input  logic [7:0]  bus_rdata,
    output logic        dma_active
`ifdef OAM_DMA_STALL_COUNT_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        parity_q, parity_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        trigger;

    assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
        end
    end

    // In HALT the following cycle has the opposite parity; a put cycle there needs ALIGN.
    always_comb begin
        state_d = state_q;
        if (ce) begin
            case (state_q)
                S_IDLE:  if (trigger) state_d = S_HALT;
                S_HALT:  state_d = parity_q ? S_READ : S_ALIGN;
                S_ALIGN: state_d = S_READ;
                S_READ:  state_d = S_WRITE;
                S_WRITE: state_d = (idx_q == 8'hFF) ? S_IDLE : S_READ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        parity_d = parity_q;
        page_d   = page_q;
        idx_d    = idx_q;
        data_d   = data_q;
        if (ce) begin
            parity_d = ~parity_q;
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        page_d = cpu_wdata;
                        idx_d  = 8'h00;
                    end
                end
                S_READ:  data_d = bus_rdata;
                S_WRITE: idx_d  = idx_q + 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        cpu_rdy    = 1'b1;
        bus_sel    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = 16'h0000;
        bus_wdata  = 8'h00;
        dma_active = 1'b0;
        case (state_q)
            S_HALT, S_ALIGN: begin
                cpu_rdy    = 1'b0;
                bus_sel    = 1'b1;
                dma_active = 1'b1;
            end
            S_READ: begin
                cpu_rdy    = 1'b0;
                bus_sel    = 1'b1;
                dma_active = 1'b1;
                bus_addr   = {page_q, idx_q};
            end
            S_WRITE: begin
                cpu_rdy    = 1'b0;
                bus_sel    = 1'b1;
                dma_active = 1'b1;
                bus_addr   = OAM_DATA_ADDR;
                bus_wdata  = data_q;
                bus_we     = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef OAM_DMA_STALL_COUNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (ce && !cpu_rdy && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= 16'h0000;
        else     stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: stimulus queues expected bus reads/writes, a monitor pops and compares them.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_we = 1'b0;
    logic        cpu_rdy, bus_sel, bus_we, dma_active;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
`ifdef OAM_DMA_STALL_COUNT_EN
    logic [15:0] stall_cycles;
`endif

    assign bus_rdata = bus_addr[7:0];

    oam_dma_ctrl dut (
        .clk(clk), .rst(rst), .ce(ce),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_rdy(cpu_rdy), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(bus_rdata),
        .dma_active(dma_active)
`ifdef OAM_DMA_STALL_COUNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    txn_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wr_count = 0;
    int   rdy_low_clk = 0;
    int   n_ce = 0;
    int   ce_div = 1;

    wire [27:0] outs = {cpu_rdy, bus_sel, bus_we, bus_addr, bus_wdata, dma_active};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ce cycle with a real bus transaction consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && ce && bus_sel && (bus_we || bus_addr != 16'h0000)) begin
            txn_t exp_t;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bus_txn we=%0b addr=%h data=%h", bus_we, bus_addr, bus_wdata);
            end else begin
                exp_t = sb_q.pop_front();
                chk(exp_t.we ? "oam_write" : "page_read",
                    {7'd0, bus_we, bus_addr, (bus_we ? bus_wdata : 8'h00)},
                    {7'd0, exp_t.we, exp_t.addr, exp_t.data});
                $display("txn we=%0b addr=%h data=%h", bus_we, bus_addr, bus_we ? bus_wdata : 8'h00);
            end
            if (bus_we) wr_count++;
        end
        if (!rst && !cpu_rdy) rdy_low_clk++;
    end

    task automatic next_ce(input logic we, input logic [15:0] addr, input logic [7:0] wd);
        logic [27:0] snap;
        for (int k = 0; k < ce_div; k++) begin
            @(posedge clk); #1;
            ce        = (k == ce_div - 1);
            cpu_we    = (k == ce_div - 1) && we;
            cpu_addr  = addr;
            cpu_wdata = wd;
            @(negedge clk);
            if (k == 0) snap = outs;
            else chk("ce_low_hold", {4'd0, outs}, {4'd0, snap});
        end
        n_ce++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; ce = 1'b0; cpu_we = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
        chk("rst_bus_sel", {31'd0, bus_sel}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", {16'd0, bus_addr}, 32'd0);
        chk("rst_bus_wdata", {24'd0, bus_wdata}, 32'd0);
        chk("rst_dma_active", {31'd0, dma_active}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n_ce = 0;
    endtask

    task automatic run_dma(input logic [7:0] page, input int want_par, input int exp_low,
                           input int inject_at, input int abort_at);
        int  low;
        bit  done;
        bit  aborted;
        low = 0; done = 0; aborted = 0;
        while ((n_ce % 2) != want_par) next_ce(1'b0, 16'h0000, 8'h00);
        wr_count = 0;
        rdy_low_clk = 0;
        for (int i = 0; i < 256; i++) begin
            sb_q.push_back('{we: 1'b0, addr: {page, i[7:0]}, data: 8'h00});
            sb_q.push_back('{we: 1'b1, addr: 16'h2004, data: i[7:0]});
        end
        next_ce(1'b1, 16'h4014, page);
        chk("trigger_cycle_rdy", {31'd0, cpu_rdy}, 32'd1);
        for (int k = 0; k < 3000 && !done && !aborted; k++) begin
            if (k == inject_at) next_ce(1'b1, 16'h4014, 8'h07);
            else next_ce(1'b0, 16'h0000, 8'h00);
            if (dma_active !== ~cpu_rdy)
                chk("active_vs_rdy", {31'd0, dma_active}, {31'd0, ~cpu_rdy});
            if (cpu_rdy == 1'b0) low++;
            else done = 1;
            if (abort_at > 0 && wr_count >= abort_at) aborted = 1;
        end
        if (aborted) begin
            do_reset();
            for (int k = 0; k < 6; k++) next_ce(1'b0, 16'h0000, 8'h00);
            chk("no_write_after_rst", wr_count, abort_at);
            chk("idle_after_rst_rdy", {31'd0, cpu_rdy}, 32'd1);
            sb_q.delete();
        end else begin
            if (!done) chk("dma_timeout", 32'd0, 32'd1);
            chk("halt_ce_cycles", low, exp_low);
            chk("write_count", wr_count, 256);
            chk("queue_drained", sb_q.size(), 0);
            chk("idle_bus_sel", {31'd0, bus_sel}, 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("init_cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
        chk("init_bus_sel", {31'd0, bus_sel}, 32'd0);
        chk("init_bus_addr", {16'd0, bus_addr}, 32'd0);
        chk("init_dma_active", {31'd0, dma_active}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n_ce = 0;

        // Even-aligned then odd-aligned transfers, back to back.
        run_dma(8'h02, 0, 513, -1, 0);
        run_dma(8'h02, 1, 514, -1, 0);
`ifdef OAM_DMA_STALL_COUNT_EN
        chk("stall_cycles_two_dma", {16'd0, stall_cycles}, 32'd1027);
`endif

        // Slow ce with an ignored retrigger mid-transfer.
        ce_div = 3;
        run_dma(8'h02, 0, 513, 50, 0);
        chk("halt_clk_cycles", rdy_low_clk, 1539);
        ce_div = 1;

        // Abort after the 100th write, then a clean full transfer.
        run_dma(8'h02, 0, 513, -1, 100);
        run_dma(8'h02, 0, 513, -1, 0);
`ifdef OAM_DMA_STALL_COUNT_EN
        chk("stall_cycles_after_rst", {16'd0, stall_cycles}, 32'd513);
`endif

        @(posedge clk); #1;
        ce = 1'b0; cpu_we = 1'b0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 Parameter DMA_REG_ADDR, default 16'h4014, CPU address whose write triggers a DMA.
REQ-002 Parameter OAM_DATA_ADDR, default 16'h2004, PPU OAM data port that receives each DMA byte.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 ce  in  1  CPU cycle enable; one pulse per CPU cycle; state advances only when ce=1.
REQ-006 cpu_addr  in  16  CPU bus address.
REQ-007 cpu_wdata  in  8  CPU write data.
REQ-008 cpu_we  in  1  CPU write strobe, qualified by ce.
REQ-009 cpu_rdy  out  1  0 = CPU halted; CPU must not advance.
REQ-010 bus_sel  out  1  1 = DMA owns the system bus; 0 = CPU owns it.
REQ-011 bus_addr  out  16  DMA bus address, valid when bus_sel=1.
REQ-012 bus_wdata  out  8  DMA write data.
REQ-013 bus_we  out  1  DMA write strobe.
REQ-014 bus_rdata  in  8  system bus read data, valid in the same ce cycle as the address.
REQ-015 dma_active  out  1  1 from the trigger-following cycle through the last write.

Function
REQ-016 A 1-bit parity register shall toggle on every ce; parity 0 = get cycle, 1 = put cycle.
REQ-017 States: IDLE, HALT, ALIGN, READ, WRITE.
REQ-018 IDLE: ce & cpu_we & cpu_addr==DMA_REG_ADDR shall latch page<=cpu_wdata, idx<=0, and go to HALT.
REQ-019 HALT lasts one ce cycle; next is ALIGN if the following cycle is a put cycle, else READ.
REQ-020 ALIGN lasts one ce cycle, then READ.
REQ-021 READ: bus_addr={page,idx}, bus_we=0; data<=bus_rdata at the ce edge; next WRITE.
REQ-022 WRITE: bus_addr=OAM_DATA_ADDR, bus_wdata=data, bus_we=1; idx<=idx+1.
REQ-023 After WRITE, idx!=255 -> READ; idx==255 -> IDLE (8-bit wrap ends the transfer, exactly 256 bytes).
REQ-024 Total halt = 1 + 512 ce cycles on even alignment, 1 + 1 + 512 on odd.
REQ-025 cpu_rdy=0, bus_sel=1, dma_active=1 in HALT, ALIGN, READ, WRITE; all return to 1/0/0 in the first IDLE cycle.
REQ-026 bus_we shall be 1 only in WRITE; bus_addr, bus_wdata shall be 0 in IDLE, HALT and ALIGN.
REQ-027 Writes to DMA_REG_ADDR while not IDLE shall be ignored.
REQ-028 A trigger write coinciding with the final WRITE shall be ignored; a new trigger is accepted only in IDLE.
REQ-029 ce=0 shall hold all state and outputs unchanged.

Reset
REQ-030 rst=1 at any clock edge shall force IDLE, parity=0, page=0, idx=0, data=0, cpu_rdy=1, bus_sel=0, bus_we=0, bus_addr=0, bus_wdata=0, dma_active=0, regardless of ce.
REQ-031 Reset mid-transfer shall abort with no further bus writes; the next DMA starts cleanly from idx 0.

Configuration
REQ-032 Macro OAM_DMA_STALL_COUNT_EN defined: output stall_cycles [15:0] shall count ce cycles with cpu_rdy=0, saturate at 16'hFFFF, and clear only on rst.
REQ-033 Macro undefined: port stall_cycles and its counter shall be absent; all other behaviour identical.

Verification
REQ-034 Write 8'h02 to 16'h4014 on an even cycle, bus_rdata=low address byte -> reads 16'h0200..16'h02FF, 256 writes to 16'h2004 with data 8'h00..8'hFF, cpu_rdy low 513 ce cycles.
REQ-035 Same trigger on an odd cycle -> one ALIGN cycle, cpu_rdy low 514 ce cycles.
REQ-036 ce pulsing every 3rd clk -> identical bus sequence, halt of 513 ce = 1539 clk.
REQ-037 Second write to 16'h4014 (8'h07) during a transfer -> ignored; page stays 8'h02; no address 16'h07xx appears.
REQ-038 rst asserted after the 100th OAM write -> next clock cpu_rdy=1, bus_sel=0, bus_we=0; a new trigger yields a full 256-byte transfer from idx 0.
REQ-039 With OAM_DMA_STALL_COUNT_EN: two back-to-back DMAs (even, then odd) -> stall_cycles=1027; without the macro the bench compiles with no stall_cycles port.
